// File: rtl/seg_digit_renderer.sv
`default_nettype none
// ============================================================================
// Module      : seg_digit_renderer
// Description : Seven-segment digit renderer for the VGA clock display.
//               Draws NUM_DIGITS BCD digits at parameterised screen positions
//               with a frame-synchronous (tear-free) value update, per-digit
//               blinking, leading-zero suppression, a dash glyph for non-BCD
//               nibbles and a two-stage registered pixel pipeline.
//
// Ports       : clk          pixel clock
//               rst          asynchronous active-high reset
//               big_bin      BCD value, nibble i drives digit i (0 = rightmost)
//               load         one-cycle strobe capturing big_bin
//               hcounterer   current pixel column
//               vcounterer   current pixel row
//               blank        high outside the active video region
//               blink_mask   bit i set: digit i blinks
//               lzs_en       leading-zero suppression enable
//               isContained  bit i: pixel lies on a lit segment of digit i
//               pixel_on     OR of isContained
//               pending      a captured value waits for the next frame start
//
// Latency     : counters sampled at edge k are reflected on isContained and
//               pixel_on after edge k+1 (two registered stages).
// Revision    : 1.0 - initial release
// ============================================================================
module seg_digit_renderer #(
    parameter int NUM_DIGITS   = 4,
    parameter int X0           = 120,
    parameter int PITCH        = 90,
    parameter int GAP_AFTER    = 2,
    parameter int GAP          = 30,
    parameter int Y_BOTTOM     = 340,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   big_bin,
    input  logic                      load,
    input  logic [10:0]               hcounterer,
    input  logic [9:0]                vcounterer,
    input  logic                      blank,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      lzs_en,
    output logic [NUM_DIGITS-1:0]     isContained,
    output logic                      pixel_on,
    output logic                      pending
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Blink counter only needs to count 0..BLINK_FRAMES-1; keep at least 1 bit.
    localparam int c_CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_CNT_W-1:0] c_BLINK_LAST = c_CNT_W'(BLINK_FRAMES - 1);

    // Glyph rows, all relative to the bottom row T of the glyph.
    localparam logic [11:0] c_T = 12'(Y_BOTTOM);

    // Segment bit positions inside a 7-bit pattern.
    localparam int c_SEG_A = 0;
    localparam int c_SEG_B = 1;
    localparam int c_SEG_C = 2;
    localparam int c_SEG_D = 3;
    localparam int c_SEG_E = 4;
    localparam int c_SEG_F = 5;
    localparam int c_SEG_G = 6;

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    function automatic logic in_range(input logic [11:0] val,
                                      input logic [11:0] lo,
                                      input logic [11:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

    // Which segment boxes of a digit whose left edge is x contain (h, v).
    // The boxes overlap nothing horizontally across digits as long as
    // PITCH > 60, but each digit is evaluated independently regardless.
    function automatic logic [6:0] box_hits(input logic [11:0] h,
                                            input logic [11:0] v,
                                            input logic [11:0] x);
        logic [6:0] hits;
        logic       col_mid;
        logic       col_left;
        logic       col_right;
        col_left  = in_range(h, x,          x + 12'd15);
        col_mid   = in_range(h, x + 12'd17, x + 12'd43);
        col_right = in_range(h, x + 12'd45, x + 12'd60);
        hits          = '0;
        hits[c_SEG_A] = col_mid   && in_range(v, c_T - 12'd200, c_T - 12'd160);
        hits[c_SEG_B] = col_right && in_range(v, c_T - 12'd200, c_T - 12'd97);
        hits[c_SEG_C] = col_right && in_range(v, c_T - 12'd93,  c_T);
        hits[c_SEG_D] = col_mid   && in_range(v, c_T - 12'd40,  c_T);
        hits[c_SEG_E] = col_left  && in_range(v, c_T - 12'd93,  c_T);
        hits[c_SEG_F] = col_left  && in_range(v, c_T - 12'd200, c_T - 12'd97);
        hits[c_SEG_G] = col_mid   && in_range(v, c_T - 12'd115, c_T - 12'd85);
        return hits;
    endfunction

    // Segment pattern {G,F,E,D,C,B,A}; non-BCD nibbles render as a dash.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'b011_1111;
            4'd1:    pat = 7'b000_0110;
            4'd2:    pat = 7'b101_1011;
            4'd3:    pat = 7'b100_1111;
            4'd4:    pat = 7'b110_0110;
            4'd5:    pat = 7'b110_1101;
            4'd6:    pat = 7'b111_1101;
            4'd7:    pat = 7'b000_0111;
            4'd8:    pat = 7'b111_1111;
            4'd9:    pat = 7'b110_1111;
            default: pat = 7'b100_0000;
        endcase
        return pat;
    endfunction

    // ------------------------------------------------------------------------
    // Frame start detection
    // ------------------------------------------------------------------------
    logic w_frame_start;
    assign w_frame_start = (hcounterer == 11'd0) && (vcounterer == 10'd0);

    // ------------------------------------------------------------------------
    // Value capture: shadow register + displayed register.
    // The displayed value only changes on frame start, so a frame is never
    // drawn with a mix of old and new digits. A load coinciding with frame
    // start bypasses the shadow so it is not delayed by a whole frame.
    // ------------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_displayed;
    logic                    r_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow    <= '0;
            r_displayed <= '0;
            r_pending   <= 1'b0;
        end else if (load && w_frame_start) begin
            r_shadow    <= big_bin;
            r_displayed <= big_bin;
            r_pending   <= 1'b0;
        end else if (w_frame_start && r_pending) begin
            r_displayed <= r_shadow;
            r_pending   <= 1'b0;
        end else if (load) begin
            r_shadow    <= big_bin;
            r_pending   <= 1'b1;
        end
    end

    assign pending = r_pending;

    // ------------------------------------------------------------------------
    // Blink timing: phase toggles every BLINK_FRAMES frame starts.
    // ------------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_blink_cnt;
    logic               r_blink_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_start) begin
            if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Leading-zero suppression: walk from the most significant digit down,
    // tracking whether everything seen so far is zero. Digit 0 is excluded
    // so a zero value still shows a single "0".
    // ------------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] w_suppress;

    always_comb begin
        logic w_all_zero;
        w_all_zero = 1'b1;
        w_suppress = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_all_zero    = w_all_zero && (r_displayed[4*i +: 4] == 4'd0);
            w_suppress[i] = lzs_en && w_all_zero;
        end
    end

    // ------------------------------------------------------------------------
    // Per-digit stage 1 inputs and stage 2 combine
    // ------------------------------------------------------------------------
    logic [11:0] w_h;
    logic [11:0] w_v;
    assign w_h = {1'b0, hcounterer};
    assign w_v = {2'b00, vcounterer};

    logic [NUM_DIGITS-1:0][6:0] w_hit;
    logic [NUM_DIGITS-1:0][6:0] w_glyph;
    logic [NUM_DIGITS-1:0]      w_visible;
    logic [NUM_DIGITS-1:0]      w_lit;

    logic [NUM_DIGITS-1:0][6:0] r_hit;
    logic [NUM_DIGITS-1:0][6:0] r_glyph;
    logic [NUM_DIGITS-1:0]      r_visible;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        // Digits are placed left to right from the most significant one.
        localparam int          c_K  = NUM_DIGITS - 1 - gi;
        localparam int          c_XI = X0 + c_K * PITCH + ((c_K >= GAP_AFTER) ? GAP : 0);
        localparam logic [11:0] c_X  = 12'(c_XI);

        assign w_hit[gi]     = blank ? 7'd0 : box_hits(w_h, w_v, c_X);
        assign w_glyph[gi]   = glyph(r_displayed[4*gi +: 4]);
        assign w_visible[gi] = !(r_blink_phase && blink_mask[gi]) && !w_suppress[gi];
        assign w_lit[gi]     = r_visible[gi] && (|(r_hit[gi] & r_glyph[gi]));
    end

    // ------------------------------------------------------------------------
    // Stage 1: segment hits, plus the glyph and visibility of the displayed
    // value as seen at the same edge. Capturing the glyph here keeps a pixel
    // sampled on the frame-start cycle paired with the outgoing value.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit     <= '0;
            r_glyph   <= '0;
            r_visible <= '0;
        end else begin
            r_hit     <= w_hit;
            r_glyph   <= w_glyph;
            r_visible <= w_visible;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: final per-digit containment and the combined pixel.
    // ------------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] r_contained;
    logic                  r_pixel_on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_contained <= '0;
            r_pixel_on  <= 1'b0;
        end else begin
            r_contained <= w_lit;
            r_pixel_on  <= |w_lit;
        end
    end

    assign isContained = r_contained;
    assign pixel_on    = r_pixel_on;

endmodule
`default_nettype wire

// File: tb/tb_seg_digit_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_digit_renderer
// Description : Self-checking bench for seg_digit_renderer. Directed
//               sequences for reset, frame sync, latency, blank, leading-zero
//               suppression, blink and dash/bypass, followed by randomized
//               stimulus compared against a behavioural pixel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_digit_renderer;

    localparam int N        = 4;
    localparam int X0       = 120;
    localparam int PITCH    = 90;
    localparam int GAP_AFT  = 2;
    localparam int GAP      = 30;
    localparam int YB       = 340;
    localparam int BF       = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [4*N-1:0] big_bin;
    logic          load;
    logic [10:0]   hcounterer;
    logic [9:0]    vcounterer;
    logic          blank;
    logic [N-1:0]  blink_mask;
    logic          lzs_en;
    logic [N-1:0]  isContained;
    logic          pixel_on;
    logic          pending;

    seg_digit_renderer #(
        .NUM_DIGITS  (N),
        .X0          (X0),
        .PITCH       (PITCH),
        .GAP_AFTER   (GAP_AFT),
        .GAP         (GAP),
        .Y_BOTTOM    (YB),
        .BLINK_FRAMES(BF)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .big_bin    (big_bin),
        .load       (load),
        .hcounterer (hcounterer),
        .vcounterer (vcounterer),
        .blank      (blank),
        .blink_mask (blink_mask),
        .lzs_en     (lzs_en),
        .isContained(isContained),
        .pixel_on   (pixel_on),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: segment boxes and glyphs written as tables.
    // ------------------------------------------------------------------------
    string seg_names = "ABCDEFG";
    string glyph_tbl[16] = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG", "ACDFG",
                             "ACDEFG", "ABC", "ABCDEFG", "ABCDFG",
                             "G", "G", "G", "G", "G", "G"};
    // Column span (dx) and row span (offset above bottom row) per segment A..G.
    int bx_lo[7]  = '{17, 45, 45, 17,  0,  0,  17};
    int bx_hi[7]  = '{43, 60, 60, 43, 15, 15,  43};
    int by_top[7] = '{200, 200, 93, 40, 93, 200, 115};
    int by_bot[7] = '{160,  97,  0,  0,  0,  97,  85};

    function automatic int left_edge(input int i);
        int k;
        k = N - 1 - i;
        return X0 + k * PITCH + ((k >= GAP_AFT) ? GAP : 0);
    endfunction

    function automatic bit glyph_has(input int nib, input int s);
        string g;
        g = glyph_tbl[nib];
        for (int j = 0; j < g.len(); j++)
            if (g[j] == seg_names[s]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [N-1:0] ref_pixel(input int h, input int v, input bit bl,
                                               input logic [4*N-1:0] disp, input int frames,
                                               input logic [N-1:0] mask, input bit lzs);
        logic [N-1:0] res;
        res = '0;
        for (int i = 0; i < N; i++) begin
            int  dx;
            int  nib;
            bit  on;
            dx  = h - left_edge(i);
            nib = int'(disp[4*i +: 4]);
            on  = 1'b0;
            for (int s = 0; s < 7; s++)
                if (dx >= bx_lo[s] && dx <= bx_hi[s] &&
                    v >= YB - by_top[s] && v <= YB - by_bot[s] && glyph_has(nib, s))
                    on = 1'b1;
            if (bl) on = 1'b0;
            if (((frames / BF) % 2 == 1) && mask[i]) on = 1'b0;
            if (lzs && i >= 1 && ((disp >> (4 * i)) == 0)) on = 1'b0;
            res[i] = on;
        end
        return res;
    endfunction

    // Model state
    logic [4*N-1:0] m_disp;
    logic [4*N-1:0] m_shadow;
    bit             m_pending;
    int             m_frames;
    logic [N-1:0]   exp_q[$];

    task automatic model_reset();
        m_disp    = '0;
        m_shadow  = '0;
        m_pending = 1'b0;
        m_frames  = 0;
        exp_q     = {};
        exp_q.push_back('0);
    endtask

    // One clock: sample outputs after the edge and compare against the model.
    task automatic tick();
        logic [N-1:0] exp_now;
        bit           fs;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
            exp_now = '0;
        end else begin
            exp_q.push_back(ref_pixel(int'(hcounterer), int'(vcounterer), blank, m_disp,
                                      m_frames, blink_mask, lzs_en));
            exp_now = exp_q.pop_front();
            fs = (hcounterer == 0) && (vcounterer == 0);
            if (load && fs) begin
                m_disp    = big_bin;
                m_pending = 1'b0;
            end else if (fs && m_pending) begin
                m_disp    = m_shadow;
                m_pending = 1'b0;
            end else if (load) begin
                m_shadow  = big_bin;
                m_pending = 1'b1;
            end
            if (fs) m_frames++;
        end
        check_eq("isContained", 32'(isContained), 32'(exp_now));
        check_eq("pixel_on", 32'(pixel_on), 32'(|exp_now));
        check_eq("pending", 32'(pending), 32'(m_pending));
    endtask

    task automatic set_px(input int h, input int v);
        hcounterer = 11'(h);
        vcounterer = 10'(v);
    endtask

    task automatic bypass_load(input logic [4*N-1:0] val);
        set_px(0, 0);
        load    = 1'b1;
        big_bin = val;
        tick();
        load    = 1'b0;
    endtask

    task automatic show(input int h, input int v);
        set_px(h, v);
        tick();
        tick();
    endtask

    bit blink_exp[7] = '{1, 1, 0, 0, 1, 1, 0};

    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        big_bin    = '0;
        blank      = 1'b0;
        blink_mask = '0;
        lzs_en     = 1'b0;
        set_px(5, 5);
        model_reset();
        repeat (3) tick();
        @(negedge clk) rst = 1'b0;

        // Value 0 after reset: G of digit 0 is off.
        show(440, 240);
        check_eq("rst_g0", 32'(isContained), 32'h0);

        // Frame-synchronous update.
        set_px(300, 100);
        load    = 1'b1;
        big_bin = 16'h1234;
        tick();
        load    = 1'b0;
        check_eq("fs_pending", 32'(pending), 32'h1);
        set_px(440, 240);
        repeat (4) tick();
        check_eq("fs_hold", 32'(isContained), 32'h0);
        set_px(0, 0);
        tick();
        check_eq("fs_clear", 32'(pending), 32'h0);
        show(440, 240);
        check_eq("fs_g4", 32'(isContained), 32'h1);

        // Asynchronous reset while lit and pending.
        load    = 1'b1;
        big_bin = 16'h5555;
        tick();
        load    = 1'b0;
        check_eq("ar_pend_pre", 32'(pending), 32'h1);
        check_eq("ar_lit_pre", 32'(pixel_on), 32'h1);
        #3 rst = 1'b1;
        #1;
        check_eq("ar_cont", 32'(isContained), 32'h0);
        check_eq("ar_pix", 32'(pixel_on), 32'h0);
        check_eq("ar_pend", 32'(pending), 32'h0);
        model_reset();
        tick();
        @(negedge clk) rst = 1'b0;
        show(440, 240);
        check_eq("ar_after", 32'(isContained), 32'h0);

        // Latency and blank with value 8.
        bypass_load(16'h0008);
        check_eq("lat_pend", 32'(pending), 32'h0);
        show(419, 300);
        set_px(420, 300);
        tick();
        check_eq("lat_k", 32'(isContained[0]), 32'h0);
        tick();
        check_eq("lat_k1", 32'(isContained[0]), 32'h1);
        blank = 1'b1;
        repeat (3) tick();
        check_eq("blank", 32'(isContained), 32'h0);
        blank = 1'b0;

        // Leading-zero suppression.
        lzs_en = 1'b1;
        bypass_load(16'h0050);
        show(125, 300);
        check_eq("lzs_d3", 32'(isContained), 32'h0);
        show(215, 300);
        check_eq("lzs_d2", 32'(isContained), 32'h0);
        show(350, 160);
        check_eq("lzs_d1", 32'(isContained), 32'h2);
        show(425, 300);
        check_eq("lzs_d0", 32'(isContained), 32'h1);
        bypass_load(16'h0000);
        show(425, 300);
        check_eq("lzs0_d0", 32'(isContained), 32'h1);
        show(335, 300);
        check_eq("lzs0_d1", 32'(isContained), 32'h0);
        lzs_en = 1'b0;

        // Dash glyph via bypass load.
        bypass_load(16'h000A);
        check_eq("dash_pend", 32'(pending), 32'h0);
        show(440, 240);
        check_eq("dash_g", 32'(isContained), 32'h1);
        show(470, 300);
        check_eq("dash_c", 32'(isContained), 32'h0);

        // Blink: reset so frame numbering starts at 0.
        @(negedge clk) rst = 1'b1;
        model_reset();
        tick();
        @(negedge clk) rst = 1'b0;
        blink_mask = 4'b0001;
        set_px(300, 50);
        load    = 1'b1;
        big_bin = 16'h8888;
        tick();
        load    = 1'b0;
        for (int f = 1; f <= 6; f++) begin
            set_px(0, 0);
            tick();
            show(440, 240);
            check_eq($sformatf("blink_d0_f%0d", f), 32'(isContained[0]), 32'(blink_exp[f]));
            show(130, 240);
            check_eq($sformatf("blink_d3_f%0d", f), 32'(isContained[3]), 32'h1);
        end

        // Randomized stimulus against the model.
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                set_px(0, 0);
            end else if (r < 8) begin
                set_px(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
            end else begin
                set_px(left_edge(int'($urandom_range(0, N - 1))) + int'($urandom_range(0, 63)) - 1,
                       YB - 205 + int'($urandom_range(0, 210)));
            end
            load = ($urandom_range(0, 7) == 0);
            for (int d = 0; d < N; d++)
                big_bin[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            blank = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) blink_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) lzs_en = 1'($urandom_range(0, 1));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
